// File: rtl/carry_save_resolver.sv
// carry_save_resolver
// Turns the redundant carry-save pair (C, S) from the squaring compressor tree
// into one binary word, sum = C + S. The addition runs one SEG_W-bit slice per
// cycle, LSB slice first, and a register carries between slices. No carry chain
// is longer than SEG_W bits.
//
// Ports
//   clk        in   1         rising-edge clock
//   reset      in   1         asynchronous, active-high reset
//   in_valid   in   1         C/S pair valid
//   in_ready   out  1         block can accept a pair (decoded from state == IDLE)
//   C          in   NUM_BITS  carry vector, already weight-aligned with S
//   S          in   NUM_BITS  sum vector
//   out_valid  out  1         sum/carry_out valid
//   out_ready  in   1         consumer accepts the result
//   sum        out  NUM_BITS  (C + S) mod 2^NUM_BITS
//   carry_out  out  1         bit NUM_BITS of C + S
module carry_save_resolver #(
   parameter int unsigned NUM_BITS = 2112,
   parameter int unsigned SEG_W    = 132
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NUM_BITS-1:0] C,
   input  logic [NUM_BITS-1:0] S,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NUM_BITS-1:0] sum,
   output logic                carry_out
);

   localparam int unsigned NUM_SEGS = NUM_BITS / SEG_W;
   localparam int unsigned CNT_W    = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
   localparam int unsigned IDX_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

   // The slices must tile the word exactly.
   if ((NUM_BITS % SEG_W) != 0) begin : g_seg_check
      $error("carry_save_resolver: NUM_BITS (%0d) must be a multiple of SEG_W (%0d)",
             NUM_BITS, SEG_W);
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [NUM_BITS-1:0] c_q, c_d;
   logic [NUM_BITS-1:0] s_q, s_d;
   logic                carry_q, carry_d;
   logic [CNT_W-1:0]    seg_cnt_q, seg_cnt_d;
   logic [NUM_BITS-1:0] sum_q, sum_d;
   logic                carry_out_q, carry_out_d;
   logic                out_valid_q, out_valid_d;

   logic [IDX_W-1:0]    seg_base;
   logic [SEG_W-1:0]    c_seg;
   logic [SEG_W-1:0]    s_seg;
   logic [SEG_W:0]      seg_add;
   logic                seg_last;

   // Slice k of the held operands, added with the carry from slice k-1.
   always_comb begin
      seg_base = IDX_W'(seg_cnt_q) * IDX_W'(SEG_W);
      c_seg    = c_q[seg_base +: SEG_W];
      s_seg    = s_q[seg_base +: SEG_W];
      seg_add  = {1'b0, c_seg} + {1'b0, s_seg} + (SEG_W+1)'(carry_q);
      seg_last = (seg_cnt_q == CNT_W'(NUM_SEGS - 1));
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d     = state_q;
      c_d         = c_q;
      s_d         = s_q;
      carry_d     = carry_q;
      seg_cnt_d   = seg_cnt_q;
      sum_d       = sum_q;
      carry_out_d = carry_out_q;
      out_valid_d = out_valid_q;

      unique case (state_q)
         ST_IDLE: begin
            // sum/carry_out keep the previous result through the accept edge.
            if (in_valid) begin
               c_d       = C;
               s_d       = S;
               carry_d   = 1'b0;
               seg_cnt_d = '0;
               state_d   = ST_ADD;
            end
         end

         ST_ADD: begin
            sum_d[seg_base +: SEG_W] = seg_add[SEG_W-1:0];
            carry_d                  = seg_add[SEG_W];
            if (seg_last) begin
               carry_out_d = seg_add[SEG_W];
               out_valid_d = 1'b1;
               seg_cnt_d   = '0;
               state_d     = ST_DONE;
            end else begin
               seg_cnt_d = seg_cnt_q + CNT_W'(1);
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         c_q         <= '0;
         s_q         <= '0;
         carry_q     <= 1'b0;
         seg_cnt_q   <= '0;
         sum_q       <= '0;
         carry_out_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         c_q         <= c_d;
         s_q         <= s_d;
         carry_q     <= carry_d;
         seg_cnt_q   <= seg_cnt_d;
         sum_q       <= sum_d;
         carry_out_q <= carry_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   // in_ready follows the state register so reset raises it at once.
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign carry_out = carry_out_q;

endmodule

// File: tb/tb_carry_save_resolver.sv
// tb_carry_save_resolver
// Self-checking bench for carry_save_resolver. Directed cases cover latency,
// full ripple, segment boundaries, backpressure and reset mid-operation.
// A random phase follows. Every expected result is the plain wide sum C + S.
module tb_carry_save_resolver;

   localparam int unsigned NB      = 2112;
   localparam int unsigned SW      = 132;
   localparam int unsigned NSEG    = NB / SW;
   localparam int unsigned N_RAND  = 1000;
   localparam int unsigned MAX_CYC = 80000;

   typedef logic [NB:0] wide_t;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [NB-1:0] c_in;
   logic [NB-1:0] s_in;
   logic          out_valid;
   logic          out_ready;
   logic [NB-1:0] sum;
   logic          carry_out;

   int n_checks = 0;
   int n_errors = 0;

   carry_save_resolver #(.NUM_BITS(NB), .SEG_W(SW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .C         (c_in),
      .S         (s_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value. Print the top bit and the low 128 bits.
   task automatic check(input string tag, input wide_t obs, input wide_t exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got top=%b low=%h, expected top=%b low=%h",
                  tag, obs[NB], obs[127:0], exp[NB], exp[127:0]);
      end
   endtask

   function automatic logic [NB-1:0] rand_word();
      logic [NB-1:0] w;
      w = '0;
      for (int i = 0; i < int'((NB + 31) / 32); i++) w = (w << 32) | NB'($urandom);
      return w;
   endfunction

   // Mostly random words, with all-ones, zero and one-hot words mixed in.
   function automatic logic [NB-1:0] rand_operand();
      logic [NB-1:0] one;
      one = NB'(1);
      case ($urandom_range(0, 7))
         0:       return '1;
         1:       return '0;
         2:       return one << $urandom_range(0, NB - 1);
         default: return rand_word();
      endcase
   endfunction

   function automatic wide_t ref_add(input logic [NB-1:0] a, input logic [NB-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   // Send one pair with out_ready held high. Check latency, result and release.
   // Entered and left on a falling edge.
   task automatic do_pair(input logic [NB-1:0] c, input logic [NB-1:0] s, input string tag);
      int    edges;
      wide_t exp;
      exp = ref_add(c, s);
      check({tag, "_in_ready"}, wide_t'(in_ready), wide_t'(1));
      c_in = c; s_in = s; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      // The DUT must use its own copies of C and S after the accept edge.
      in_valid = 1'b0; c_in = rand_word(); s_in = rand_word();
      edges = 0;
      while (!out_valid && edges < int'(4 * NSEG)) begin
         @(posedge clk); #1;
         edges++;
      end
      check({tag, "_latency"}, wide_t'(edges), wide_t'(NSEG));
      check({tag, "_result"}, {carry_out, sum}, exp);
      @(posedge clk); #1;
      check({tag, "_release"}, wide_t'({in_ready, out_valid}), wide_t'(2'b10));
      @(negedge clk);
   endtask

   logic [NB-1:0] one_w;
   logic [NB-1:0] a_c, a_s, b_c, b_s;
   wide_t         q[$];
   wide_t         exp_w;
   int            edges;
   int            sent, got, cyc;
   logic          fire_in;

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; c_in = '0; s_in = '0;
      one_w = NB'(1);
      #1;
      check("reset_outputs", wide_t'({in_ready, out_valid, carry_out}), wide_t'(3'b100));
      check("reset_sum", wide_t'(sum), '0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Latency and basic add.
      do_pair(NB'(5), NB'(7), "lat_5_7");
      // One carry ripples through every slice.
      do_pair('1, NB'(1), "full_ripple");
      // A carry crosses from slice 0 into slice 1.
      do_pair(one_w << (SW - 1), one_w << (SW - 1), "seg_boundary");
      // The carry leaves the top bit.
      do_pair(one_w << (NB - 1), one_w << (NB - 1), "top_wrap");

      // Backpressure: the second pair waits through DONE until the handshake.
      a_c = rand_word(); a_s = rand_word(); b_c = rand_word(); b_s = rand_word();
      c_in = a_c; s_in = a_s; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      c_in = b_c; s_in = b_s;
      edges = 0;
      while (!out_valid && edges < int'(4 * NSEG)) begin
         @(posedge clk); #1;
         edges++;
      end
      check("bp_latency", wide_t'(edges), wide_t'(NSEG));
      exp_w = ref_add(a_c, a_s);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_hold_result", {carry_out, sum}, exp_w);
         check("bp_hold_flags", wide_t'({in_ready, out_valid}), wide_t'(2'b01));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_handshake", wide_t'({in_ready, out_valid}), wide_t'(2'b10));
      check("bp_result_kept", {carry_out, sum}, exp_w);
      @(posedge clk); #1;
      in_valid = 1'b0; c_in = '0; s_in = '0;
      check("bp_second_accept", wide_t'(in_ready), '0);
      edges = 0;
      while (!out_valid && edges < int'(4 * NSEG)) begin
         @(posedge clk); #1;
         edges++;
      end
      check("bp_second_latency", wide_t'(edges), wide_t'(NSEG));
      check("bp_second_result", {carry_out, sum}, ref_add(b_c, b_s));
      @(posedge clk); #1;
      @(negedge clk);

      // Reset seven slices into an addition.
      c_in = '1; s_in = rand_word() | NB'(1); in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("mid_reset_flags", wide_t'({in_ready, out_valid, carry_out}), wide_t'(3'b100));
      check("mid_reset_sum", wide_t'(sum), '0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_reset_idle", wide_t'({in_ready, out_valid}), wide_t'(2'b10));
      do_pair(NB'(3), NB'(4), "post_reset");

      // Random traffic with gaps on both sides, checked against an in-order scoreboard.
      sent = 0; got = 0; cyc = 0; fire_in = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0;
      while (got < int'(N_RAND) && cyc < int'(MAX_CYC)) begin
         @(negedge clk);
         cyc++;
         if (fire_in) begin
            in_valid = 1'b0;
            fire_in  = 1'b0;
         end
         if (!in_valid && sent < int'(N_RAND) && $urandom_range(0, 1) == 1) begin
            c_in = rand_operand(); s_in = rand_operand(); in_valid = 1'b1;
            sent++;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         if (in_valid && in_ready) begin
            q.push_back(ref_add(c_in, s_in));
            fire_in = 1'b1;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("rand_unexpected_result", {carry_out, sum}, '0);
            end else begin
               check("rand_result", {carry_out, sum}, q.pop_front());
            end
            got++;
         end
      end
      check("rand_result_count", wide_t'(got), wide_t'(N_RAND));
      check("rand_scoreboard_empty", wide_t'(q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
